// File: rtl/xbar_req_dispatcher_if.sv
// rtl/xbar_req_dispatcher_if.sv - master request, slave issue and sequencer tag-FIFO signals of the dispatcher
interface xbar_req_dispatcher_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 2
);
  localparam int NSLAVES = 1 << TAG_WIDTH;

  logic                  m_req_i;
  logic                  m_we_i;
  logic [ADDR_WIDTH-1:0] m_addr_bi;
  logic [DATA_WIDTH-1:0] m_wdata_bi;
  logic                  m_ack_o;
  logic [NSLAVES-1:0]    s_req_o;
  logic [NSLAVES-1:0]    s_ack_i;
  logic                  s_we_o;
  logic [ADDR_WIDTH-1:0] s_addr_bo;
  logic [DATA_WIDTH-1:0] s_wdata_bo;
  logic                  tag_fifo_full_i;
  logic                  tag_fifo_wrreq_o;
  logic [TAG_WIDTH-1:0]  tag_fifo_wdata_o;
  logic                  rd_done_i;
  logic [3:0]            outstanding_o;

  // Dispatcher view
  modport slave (
    input  m_req_i, m_we_i, m_addr_bi, m_wdata_bi, s_ack_i, tag_fifo_full_i, rd_done_i,
    output m_ack_o, s_req_o, s_we_o, s_addr_bo, s_wdata_bo,
           tag_fifo_wrreq_o, tag_fifo_wdata_o, outstanding_o
  );

  // Environment view: requesting master, slaves and response sequencer
  modport master (
    output m_req_i, m_we_i, m_addr_bi, m_wdata_bi, s_ack_i, tag_fifo_full_i, rd_done_i,
    input  m_ack_o, s_req_o, s_we_o, s_addr_bo, s_wdata_bo,
           tag_fifo_wrreq_o, tag_fifo_wdata_o, outstanding_o
  );
endinterface

// File: rtl/xbar_req_dispatcher.sv
// rtl/xbar_req_dispatcher.sv - crossbar master request stage: slave decode, req/ack issue, read tag push
module xbar_req_dispatcher #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TAG_WIDTH       = 2,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  xbar_req_dispatcher_if.slave bus
);
  localparam int NSLAVES = 1 << TAG_WIDTH;

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                state_q;
  logic [TAG_WIDTH-1:0]  tag_q;
  logic [NSLAVES-1:0]    s_req_q;
  logic                  s_we_q;
  logic [ADDR_WIDTH-1:0] s_addr_q;
  logic [DATA_WIDTH-1:0] s_wdata_q;
  logic [3:0]            outstanding_q;

  logic [TAG_WIDTH-1:0]  tag_d;
  logic                  rd_room;
  logic                  accept;
  logic                  rd_accept;
  logic                  rd_dec;

  assign tag_d   = bus.m_addr_bi[ADDR_WIDTH-1 -: TAG_WIDTH];
  assign rd_room = !bus.tag_fifo_full_i && (outstanding_q < 4'(MAX_OUTSTANDING));
  // Gated by rst_i so nothing is acknowledged or pushed while reset is held
  assign accept    = rst_i && (state_q == IDLE) && bus.m_req_i && (bus.m_we_i || rd_room);
  assign rd_accept = accept && !bus.m_we_i;
  assign rd_dec    = bus.rd_done_i && (outstanding_q != 4'd0);

  assign bus.m_ack_o          = accept;
  assign bus.tag_fifo_wrreq_o = rd_accept;
  assign bus.tag_fifo_wdata_o = tag_d;
  assign bus.s_req_o          = s_req_q;
  assign bus.s_we_o           = s_we_q;
  assign bus.s_addr_bo        = s_addr_q;
  assign bus.s_wdata_bo       = s_wdata_q;
  assign bus.outstanding_o    = outstanding_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q       <= IDLE;
      tag_q         <= '0;
      s_req_q       <= '0;
      s_we_q        <= 1'b0;
      s_addr_q      <= '0;
      s_wdata_q     <= '0;
      outstanding_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= ISSUE;
            tag_q     <= tag_d;
            s_req_q   <= NSLAVES'(1) << tag_d;
            s_we_q    <= bus.m_we_i;
            s_addr_q  <= bus.m_addr_bi;
            s_wdata_q <= bus.m_wdata_bi;
          end
        end
        ISSUE: begin
          // Only the addressed slave can complete the issue
          if (bus.s_ack_i[tag_q]) begin
            state_q <= IDLE;
            s_req_q <= '0;
          end
        end
        default: state_q <= IDLE;
      endcase

      case ({rd_accept, rd_dec})
        2'b10:   outstanding_q <= outstanding_q + 4'd1;
        2'b01:   outstanding_q <= outstanding_q - 4'd1;
        default: outstanding_q <= outstanding_q;
      endcase
    end
  end
endmodule

// File: tb/tb_xbar_req_dispatcher.sv
// tb/tb_xbar_req_dispatcher.sv - table vectors, corner sequences and random traffic against a transaction model
module tb_xbar_req_dispatcher;
  localparam int AW = 32, DW = 32, TW = 2, MAXO = 8;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  always #5 clk_i = ~clk_i;

  xbar_req_dispatcher_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW)) bus ();

  xbar_req_dispatcher #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TAG_WIDTH(TW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Transaction-level model: one request in flight to a slave, plus a read counter
  bit          m_busy;
  int          m_tag;
  bit          m_swe;
  logic [31:0] m_saddr, m_swdata;
  int          m_cnt;

  typedef struct {
    bit          req, we;
    logic [31:0] addr, wdata;
    logic [3:0]  sack;
    bit          full, rd;
    bit          e_ack, e_push;
    logic [1:0]  e_tag;
    logic [3:0]  e_sreq;
    bit          e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_out;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_busy = 0; m_tag = 0; m_swe = 0; m_saddr = '0; m_swdata = '0; m_cnt = 0;
  endfunction

  function automatic bit model_accept();
    return rst_i && !m_busy && bus.m_req_i &&
           (bus.m_we_i || (!bus.tag_fifo_full_i && m_cnt < MAXO));
  endfunction

  task automatic drive(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] sack, input bit full, input bit rd);
    bus.m_req_i = req; bus.m_we_i = we; bus.m_addr_bi = addr; bus.m_wdata_bi = wdata;
    bus.s_ack_i = sack; bus.tag_fifo_full_i = full; bus.rd_done_i = rd;
  endtask

  task automatic check_model();
    bit acc;
    acc = model_accept();
    chk("m_ack", bus.m_ack_o, acc);
    chk("tag_push", bus.tag_fifo_wrreq_o, acc && !bus.m_we_i);
    if (acc && !bus.m_we_i) chk("tag_value", bus.tag_fifo_wdata_o, bus.m_addr_bi[31:30]);
    chk("s_req", bus.s_req_o, m_busy ? (4'b0001 << m_tag) : 4'b0000);
    chk("s_we", bus.s_we_o, m_swe);
    chk("s_addr", bus.s_addr_bo, m_saddr);
    chk("s_wdata", bus.s_wdata_bo, m_swdata);
    chk("outstanding", bus.outstanding_o, m_cnt);
  endtask

  task automatic tick();
    bit acc, we, rd;
    logic [31:0] addr, wdata;
    logic [3:0] sa;
    acc = model_accept(); we = bus.m_we_i; rd = bus.rd_done_i;
    addr = bus.m_addr_bi; wdata = bus.m_wdata_bi; sa = bus.s_ack_i;
    @(posedge clk_i);
    if (acc) begin
      m_busy = 1; m_tag = int'(addr[31:30]); m_swe = we; m_saddr = addr; m_swdata = wdata;
    end else if (m_busy && sa[m_tag]) begin
      m_busy = 0;
    end
    m_cnt = m_cnt + ((acc && !we) ? 1 : 0) - ((rd && m_cnt > 0) ? 1 : 0);
    @(negedge clk_i);
  endtask

  task automatic cyc(input bit req, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] sack, input bit full, input bit rd);
    drive(req, we, addr, wdata, sack, full, rd);
    #1;
    check_model();
    tick();
  endtask

  // Full request: hold it until accepted, then ack from the addressed slave
  task automatic issue_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    bit acc;
    bit done;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      drive(1, we, addr, wdata, 4'b0, 0, 0);
      #1;
      acc = model_accept();
      check_model();
      tick();
      done = acc;
    end
    if (!done) chk("txn_accept_timeout", 0, 1);
    for (int i = 0; i < 20 && m_busy; i++)
      cyc(0, 0, 0, 0, 4'b0001 << addr[31:30], 0, 0);
    if (m_busy) chk("txn_ack_timeout", 0, 1);
  endtask

  initial begin
    bit pend, p_we, acc;
    logic [31:0] p_addr, p_wdata;
    logic [3:0] sack;

    tbl[0]  = '{1, 0, 32'h4000_0010, 32'h0,        4'b0000, 0, 0, 1, 1, 2'd1, 4'b0000, 0, 32'h0,         32'h0,         4'd0};
    tbl[1]  = '{0, 0, 32'h0,         32'h0,        4'b0000, 0, 0, 0, 0, 2'd0, 4'b0010, 0, 32'h4000_0010, 32'h0,         4'd1};
    tbl[2]  = '{0, 0, 32'h0,         32'h0,        4'b0000, 0, 0, 0, 0, 2'd0, 4'b0010, 0, 32'h4000_0010, 32'h0,         4'd1};
    tbl[3]  = '{0, 0, 32'h0,         32'h0,        4'b0010, 0, 0, 0, 0, 2'd0, 4'b0010, 0, 32'h4000_0010, 32'h0,         4'd1};
    tbl[4]  = '{0, 0, 32'h0,         32'h0,        4'b0000, 0, 0, 0, 0, 2'd0, 4'b0000, 0, 32'h4000_0010, 32'h0,         4'd1};
    tbl[5]  = '{1, 1, 32'hC000_0000, 32'hDEADBEEF, 4'b0000, 1, 0, 1, 0, 2'd0, 4'b0000, 0, 32'h4000_0010, 32'h0,         4'd1};
    tbl[6]  = '{0, 0, 32'h0,         32'h0,        4'b0001, 0, 0, 0, 0, 2'd0, 4'b1000, 1, 32'hC000_0000, 32'hDEADBEEF, 4'd1};
    tbl[7]  = '{0, 0, 32'h0,         32'h0,        4'b1000, 0, 0, 0, 0, 2'd0, 4'b1000, 1, 32'hC000_0000, 32'hDEADBEEF, 4'd1};
    tbl[8]  = '{1, 0, 32'h8000_0000, 32'h0,        4'b0000, 1, 0, 0, 0, 2'd0, 4'b0000, 1, 32'hC000_0000, 32'hDEADBEEF, 4'd1};
    tbl[9]  = '{1, 0, 32'h8000_0000, 32'h0,        4'b0000, 0, 1, 1, 1, 2'd2, 4'b0000, 1, 32'hC000_0000, 32'hDEADBEEF, 4'd1};
    tbl[10] = '{0, 0, 32'h0,         32'h0,        4'b0000, 0, 1, 0, 0, 2'd0, 4'b0100, 0, 32'h8000_0000, 32'h0,         4'd1};
    tbl[11] = '{0, 0, 32'h0,         32'h0,        4'b0100, 0, 1, 0, 0, 2'd0, 4'b0100, 0, 32'h8000_0000, 32'h0,         4'd0};
    tbl[12] = '{0, 0, 32'h0,         32'h0,        4'b0000, 0, 0, 0, 0, 2'd0, 4'b0000, 0, 32'h8000_0000, 32'h0,         4'd0};

    // Reset with a read already requested: nothing may be acknowledged
    model_reset();
    drive(1, 0, 32'h4000_0000, 0, 4'b0, 0, 0);
    @(negedge clk_i); @(negedge clk_i);
    #1;
    chk("rst_m_ack", bus.m_ack_o, 0);
    chk("rst_push", bus.tag_fifo_wrreq_o, 0);
    chk("rst_s_req", bus.s_req_o, 0);
    chk("rst_s_addr", bus.s_addr_bo, 0);
    chk("rst_outstanding", bus.outstanding_o, 0);
    @(negedge clk_i);
    drive(0, 0, 0, 0, 4'b0, 0, 0);
    rst_i = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].sack, tbl[i].full, tbl[i].rd);
      #1;
      chk($sformatf("tbl%0d_ack", i), bus.m_ack_o, tbl[i].e_ack);
      chk($sformatf("tbl%0d_push", i), bus.tag_fifo_wrreq_o, tbl[i].e_push);
      if (tbl[i].e_push) chk($sformatf("tbl%0d_tag", i), bus.tag_fifo_wdata_o, tbl[i].e_tag);
      chk($sformatf("tbl%0d_sreq", i), bus.s_req_o, tbl[i].e_sreq);
      chk($sformatf("tbl%0d_swe", i), bus.s_we_o, tbl[i].e_we);
      chk($sformatf("tbl%0d_saddr", i), bus.s_addr_bo, tbl[i].e_addr);
      chk($sformatf("tbl%0d_swdata", i), bus.s_wdata_bo, tbl[i].e_wdata);
      chk($sformatf("tbl%0d_out", i), bus.outstanding_o, tbl[i].e_out);
      check_model();
      tick();
    end

    // Outstanding limit: eight reads fill the budget, the ninth waits for a completion
    for (int k = 0; k < 8; k++) issue_txn(0, {k[1:0], 30'h0} + 32'(k), 0);
    chk("limit_peak", bus.outstanding_o, 8);
    for (int k = 0; k < 3; k++) begin
      drive(1, 0, 32'h4000_0100, 0, 4'b0, 0, 0);
      #1;
      chk("limit_hold_ack", bus.m_ack_o, 0);
      chk("limit_hold_push", bus.tag_fifo_wrreq_o, 0);
      check_model();
      tick();
    end
    drive(1, 0, 32'h4000_0100, 0, 4'b0, 0, 1);
    #1;
    chk("limit_done_cycle_ack", bus.m_ack_o, 0);
    check_model();
    tick();
    drive(1, 0, 32'h4000_0100, 0, 4'b0, 0, 0);
    #1;
    chk("limit_release_ack", bus.m_ack_o, 1);
    check_model();
    tick();
    for (int i = 0; i < 20 && m_busy; i++) cyc(0, 0, 0, 0, 4'b0010, 0, 0);
    chk("limit_refill", bus.outstanding_o, 8);

    // Accept and completion in the same cycle at a count of 3
    for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 4'b0, 0, 1);
    chk("drain_to_3", bus.outstanding_o, 3);
    drive(1, 0, 32'h0000_0040, 0, 4'b0, 0, 1);
    #1;
    chk("net0_ack", bus.m_ack_o, 1);
    check_model();
    tick();
    chk("net0_count", bus.outstanding_o, 3);
    for (int i = 0; i < 20 && m_busy; i++) cyc(0, 0, 0, 0, 4'b0001, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 4'b0, 0, 1);
    cyc(0, 0, 0, 0, 4'b0, 0, 1);
    chk("done_at_zero", bus.outstanding_o, 0);

    // Reset in the middle of an issue to slave 2
    cyc(1, 0, 32'h8000_0000, 0, 4'b0, 0, 0);
    drive(0, 0, 0, 0, 4'b0, 0, 0);
    #1;
    chk("issue_s_req", bus.s_req_o, 4'b0100);
    rst_i = 1'b0;
    #1;
    chk("midrst_s_req", bus.s_req_o, 0);
    chk("midrst_outstanding", bus.outstanding_o, 0);
    chk("midrst_s_addr", bus.s_addr_bo, 0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b1;
    issue_txn(0, 32'h4000_0000, 0);
    chk("post_rst_read", bus.outstanding_o, 1);

    // Random traffic; a request is held until the model says it was accepted
    pend = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!pend && $urandom_range(0, 2) != 0) begin
        pend = 1; p_we = ($urandom_range(0, 2) == 0); p_addr = $urandom; p_wdata = $urandom;
      end
      if ($urandom_range(0, 3) == 0) sack = 4'($urandom);
      else sack = (m_busy && $urandom_range(0, 1) == 1) ? (4'b0001 << m_tag) : 4'b0000;
      drive(pend, p_we, p_addr, p_wdata, sack, $urandom_range(0, 4) == 0,
            (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0));
      #1;
      acc = model_accept();
      check_model();
      tick();
      if (acc) pend = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
